// File: rtl/sample_strobe_tx.sv
// Purpose: buffers host samples in a small FIFO and replays them as one-cycle strobes with a programmable idle gap (optional PRBS source under SAMPLE_TX_PRBS_EN).
// Latency: a sample accepted into an empty FIFO while idle with ena=1 strobes on the next edge; one strobe every max(gap_cfg,1)+2 cycles.
// Backpressure: in_ready = !full from the registered count, with no same-cycle pop pass-through; ena low holds the FSM in IDLE after the current strobe/gap.

module sample_strobe_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] count;

  // Pointers wrap naturally because DEPTH is a power of two; simultaneous push/pop leaves count alone.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; only the pointers decide which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata;
  end

  assign head  = mem[rptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
endmodule

module sample_strobe_tx #(
  parameter int DEPTH = 4,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [GAP_W-1:0] gap_cfg,
  output logic [7:0]       smp_data,
  output logic             smp_strobe,
`ifdef SAMPLE_TX_PRBS_EN
  input  logic             prbs_en,
`endif
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, STROBE, GAP} state_t;

  state_t           state;
  state_t           state_nxt;
  logic             start;
  logic             pop;
  logic             push;
  logic             full;
  logic             empty;
  logic [7:0]       head;
  logic [7:0]       data_q;
  logic             strobe_q;
  logic [GAP_W-1:0] g_q;
  logic [GAP_W-1:0] cnt;
  logic [GAP_W-1:0] g_eff;

`ifdef SAMPLE_TX_PRBS_EN
  logic       use_prbs;
  logic [7:0] lfsr;
  logic [7:0] lfsr_nxt;
  // x^8+x^6+x^5+x^4+1, shifting towards the MSB
  assign lfsr_nxt = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
`endif

  // Reset gating keeps the host from pushing while the FIFO is being cleared.
  assign in_ready = rst_n & ~full;
  assign push     = in_valid & in_ready;
  // A zero gap setting still leaves one idle GAP cycle so strobes never abut.
  assign g_eff    = (gap_cfg == '0) ? GAP_W'(1) : gap_cfg;

  sample_strobe_fifo #(.DEPTH(DEPTH), .W(8)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (in_data),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  // Next-state and pop decode; pops happen only on the IDLE->STROBE edge.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    pop       = 1'b0;
`ifdef SAMPLE_TX_PRBS_EN
    use_prbs  = 1'b0;
`endif
    case (state)
      IDLE: begin
`ifdef SAMPLE_TX_PRBS_EN
        if (ena && prbs_en) begin
          start    = 1'b1;
          use_prbs = 1'b1;
        end else if (ena && !empty) begin
          start = 1'b1;
          pop   = 1'b1;
        end
`else
        if (ena && !empty) begin
          start = 1'b1;
          pop   = 1'b1;
        end
`endif
        if (start) state_nxt = STROBE;
      end
      STROBE: state_nxt = GAP;
      GAP:    if (cnt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register plus a dedicated strobe flop so smp_strobe is glitch-free.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      strobe_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      strobe_q <= (state_nxt == STROBE);
    end
  end

  // Sample/gap capture on the start edge; the gap counter runs g-1 down to 0 in GAP.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q <= 8'h00;
      g_q    <= GAP_W'(1);
      cnt    <= '0;
`ifdef SAMPLE_TX_PRBS_EN
      lfsr   <= 8'h01;
`endif
    end else begin
      if (start) begin
        g_q <= g_eff;
`ifdef SAMPLE_TX_PRBS_EN
        data_q <= use_prbs ? lfsr : head;
        if (use_prbs) lfsr <= lfsr_nxt;
`else
        data_q <= head;
`endif
      end
      if (state == STROBE) begin
        cnt <= g_q - GAP_W'(1);
      end else if (state == GAP && cnt != '0) begin
        cnt <= cnt - GAP_W'(1);
      end
    end
  end

  assign smp_data   = data_q;
  assign smp_strobe = strobe_q;
  assign busy       = ~empty | (state != IDLE);
endmodule
